// File: rtl/cavlc_scan_ctrl_if.sv
// rtl/cavlc_scan_ctrl_if.sv - coefficient buffer and statistics counter bus for cavlc_scan_ctrl
//
// Groups everything between the scan controller and its neighbours:
//   start, stall      : block request and downstream hold (into the controller)
//   coeff_addr/rd_en  : synchronous-read coefficient buffer port (from the controller)
//   coeff_rdata       : buffer read data, valid the cycle after rd_en (into the controller)
//   cnt_rst/start_cnt : clear and count-enable strobes to the statistics counters
//   coeff_o           : coefficient presented to the counters while start_cnt is high
//   total_coeff       : running count of nonzero coefficients in the block
//   busy, done        : controller status; done is a one-cycle "results final" pulse
// master = controller side, slave = buffer/counter/encoder side.

interface cavlc_scan_ctrl_if #(
  parameter int ADDR_W = 4
) ();
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] coeff_addr;
  logic              coeff_rd_en;
  logic [7:0]        coeff_rdata;
  logic              cnt_rst;
  logic              start_cnt;
  logic [7:0]        coeff_o;
  logic [4:0]        total_coeff;
  logic              busy;
  logic              done;

  modport master (
    input  start, stall, coeff_rdata,
    output coeff_addr, coeff_rd_en, cnt_rst, start_cnt, coeff_o, total_coeff, busy, done
  );

  modport slave (
    output start, stall, coeff_rdata,
    input  coeff_addr, coeff_rd_en, cnt_rst, start_cnt, coeff_o, total_coeff, busy, done
  );
endinterface

// File: rtl/cavlc_scan_ctrl.sv
// rtl/cavlc_scan_ctrl.sv - reverse zig-zag scan sequencer feeding the CAVLC statistics counters
//
// Walks one residual block from coefficient MAX_COEFF-1 down to 0, clearing the
// statistics counters first, presenting each coefficient with start_cnt, counting
// nonzero coefficients into total_coeff, and pulsing done when all results are final.
//
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   h264_reset  : synchronous active-high encoder abort, same effect as rst
//   bus         : cavlc_scan_ctrl_if master (start/stall in, buffer read port,
//                 counter strobes, coeff_o, total_coeff, busy, done)
//
// Parameters:
//   MAX_COEFF   : coefficients per block (16 luma 4x4, 15 AC, 4 chroma DC)
//   ADDR_W      : buffer address width, 2**ADDR_W >= MAX_COEFF

module cavlc_scan_ctrl #(
  parameter int MAX_COEFF = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h264_reset,
  cavlc_scan_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_COEFF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  // addr_q remembers the last address issued so the buffer port holds it
  // through stalls and after the scan ends.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        total_q, total_d;
  logic              rd_en;
  logic              any_rst;

  assign any_rst = rst | h264_reset;

  always_ff @(posedge clk) begin
    if (any_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      total_q <= total_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    total_d = total_q;
    rd_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLR;
      end

      // Prefetch the highest coefficient so it is on coeff_rdata in the first READ cycle.
      CLR: begin
        rd_en   = 1'b1;
        addr_d  = LAST_IDX;
        idx_d   = LAST_IDX;
        total_d = '0;
        state_d = READ;
      end

      // coeff_rdata holds coeff[idx]; while consuming it, fetch coeff[idx-1].
      READ: begin
        if (!bus.stall) begin
          if (bus.coeff_rdata != 8'd0) total_d = total_q + 5'd1;
          if (idx_q != '0) begin
            rd_en  = 1'b1;
            addr_d = idx_q - ADDR_W'(1);
            idx_d  = idx_q - ADDR_W'(1);
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.coeff_addr  = addr_d;
  assign bus.coeff_rd_en = rd_en;
  assign bus.cnt_rst     = (state_q == CLR);
  assign bus.start_cnt   = (state_q == READ) && !bus.stall;
  assign bus.coeff_o     = bus.coeff_rdata;
  assign bus.total_coeff = total_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_cavlc_scan_ctrl.sv
// tb/tb_cavlc_scan_ctrl.sv - directed self-checking bench for cavlc_scan_ctrl (MAX_COEFF 16/15/4)

module tb_cavlc_scan_ctrl;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  logic h264;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cavlc_scan_ctrl_if #(.ADDR_W(AW)) bus [3] ();

  logic          start_v [3];
  logic          stall_v [3];
  logic [7:0]    mem     [3][16];
  logic [7:0]    rdata_r [3];
  logic          sc_w [3], rd_w [3], clr_w [3], done_w [3], busy_w [3];
  logic [AW-1:0] addr_w [3];
  logic [7:0]    co_w   [3];
  logic [4:0]    tot_w  [3];

  function automatic int maxc(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 15 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cavlc_scan_ctrl #(
      .MAX_COEFF(g == 0 ? 16 : (g == 1 ? 15 : 4)),
      .ADDR_W   (AW)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .h264_reset(h264),
      .bus       (bus[g])
    );
    assign bus[g].start       = start_v[g];
    assign bus[g].stall       = stall_v[g];
    assign bus[g].coeff_rdata = rdata_r[g];
    assign sc_w[g]   = bus[g].start_cnt;
    assign rd_w[g]   = bus[g].coeff_rd_en;
    assign clr_w[g]  = bus[g].cnt_rst;
    assign done_w[g] = bus[g].done;
    assign busy_w[g] = bus[g].busy;
    assign addr_w[g] = bus[g].coeff_addr;
    assign co_w[g]   = bus[g].coeff_o;
    assign tot_w[g]  = bus[g].total_coeff;
  end

  // Synchronous-read coefficient buffers; rdata holds while rd_en is low.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (rd_w[i]) rdata_r[i] <= mem[i][addr_w[i]];
  end

  // Per-instance observers: event counts, address order, protocol rules,
  // and an attached total_zeros counter (zeros below the last nonzero in scan order).
  int n_sc [3] = '{default: 0};
  int n_rd [3] = '{default: 0};
  int n_done [3] = '{default: 0};
  int n_clr [3] = '{default: 0};
  int addr_err [3] = '{default: 0};
  int rule_err [3] = '{default: 0};
  int zc [3] = '{default: 0};
  int t_clr [3] = '{default: 0};
  int t_done [3] = '{default: 0};
  int first_addr [3] = '{default: 0};
  int exp_addr [3] = '{default: 0};
  int prev_addr [3] = '{default: 0};
  bit seen [3] = '{default: 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (clr_w[i]) begin
        n_clr[i]++;
        t_clr[i]      = cyc;
        first_addr[i] = int'(addr_w[i]);
        exp_addr[i]   = maxc(i) - 1;
        zc[i]         = 0;
        seen[i]       = 1'b0;
      end
      if (rd_w[i]) begin
        n_rd[i]++;
        if (int'(addr_w[i]) != exp_addr[i]) addr_err[i]++;
        exp_addr[i]--;
      end
      if (sc_w[i]) begin
        n_sc[i]++;
        if (co_w[i] != 8'd0) seen[i] = 1'b1;
        else if (seen[i]) zc[i]++;
      end
      if (done_w[i]) begin
        n_done[i]++;
        t_done[i] = cyc;
      end
      if ((clr_w[i] && sc_w[i]) || (done_w[i] && sc_w[i]) || (int'(addr_w[i]) >= maxc(i)) ||
          (stall_v[i] && busy_w[i] && !clr_w[i] && !done_w[i] &&
           (sc_w[i] || rd_w[i] || int'(addr_w[i]) != prev_addr[i])))
        rule_err[i]++;
      prev_addr[i] = int'(addr_w[i]);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  int t0, b_sc, b_rd, b_done, b_clr, b_aerr, b_rerr;

  // plan 0: plain scan; 1: stall at idx 8 (3 cycles) and idx 0 (1 cycle);
  // 2: extra start pulses in READ and DONE; 3: h264_reset at idx 7.
  task automatic scan(input int i, input int plan);
    b_sc   = n_sc[i];
    b_rd   = n_rd[i];
    b_done = n_done[i];
    b_clr  = n_clr[i];
    b_aerr = addr_err[i];
    b_rerr = rule_err[i];
    @(posedge clk); #1;
    start_v[i] = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      start_v[i] = (plan == 2) && (k == 5 || k == 18);
      stall_v[i] = (plan == 1) && (k == 9 || k == 10 || k == 11 || k == 20);
      h264       = (plan == 3) && (k == 10);
      if (plan == 3 && k == 11) begin
        @(negedge clk);
        check_eq("abort.busy", int'(busy_w[0]), 0);
        check_eq("abort.done", int'(done_w[0]), 0);
        check_eq("abort.cnt_rst", int'(clr_w[0]), 0);
        check_eq("abort.start_cnt", int'(sc_w[0]), 0);
        check_eq("abort.rd_en", int'(rd_w[0]), 0);
        check_eq("abort.addr", int'(addr_w[0]), 0);
        check_eq("abort.total", int'(tot_w[0]), 0);
      end
    end
    start_v[i] = 1'b0;
    stall_v[i] = 1'b0;
    h264       = 1'b0;
  endtask

  task automatic check_scan(input string tag, input int i, input int done_off,
                            input int first, input int tot, input int zeros);
    check_eq({tag, ".clr_off"}, t_clr[i] - t0, 1);
    check_eq({tag, ".done_off"}, t_done[i] - t0, done_off);
    check_eq({tag, ".n_done"}, n_done[i] - b_done, 1);
    check_eq({tag, ".n_clr"}, n_clr[i] - b_clr, 1);
    check_eq({tag, ".n_start_cnt"}, n_sc[i] - b_sc, maxc(i));
    check_eq({tag, ".n_rd_en"}, n_rd[i] - b_rd, maxc(i));
    check_eq({tag, ".first_addr"}, first_addr[i], first);
    check_eq({tag, ".addr_order"}, addr_err[i] - b_aerr, 0);
    check_eq({tag, ".strobe_rules"}, rule_err[i] - b_rerr, 0);
    check_eq({tag, ".total_coeff"}, int'(tot_w[i]), tot);
    check_eq({tag, ".total_zeros"}, zc[i], zeros);
    check_eq({tag, ".idle"}, int'(busy_w[i]), 0);
  endtask

  task automatic load_a();
    for (int k = 0; k < 16; k++) mem[0][k] = 8'd0;
    mem[0][0] = 8'd5;
    mem[0][2] = 8'd3;
    mem[0][5] = 8'd1;
  endtask

  initial begin
    rst  = 1'b1;
    h264 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      stall_v[i] = 1'b0;
    end
    stall_v[0] = 1'b1;
    load_a();
    for (int k = 0; k < 16; k++) begin
      mem[1][k] = (k % 2 == 1) ? 8'hff : 8'h00;
      mem[2][k] = 8'd0;
    end
    mem[2][2] = 8'd7;
    mem[2][5] = 8'd9;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset.busy", int'(busy_w[0]), 0);
    check_eq("reset.done", int'(done_w[0]), 0);
    check_eq("reset.cnt_rst", int'(clr_w[0]), 0);
    check_eq("reset.start_cnt", int'(sc_w[0]), 0);
    check_eq("reset.rd_en", int'(rd_w[0]), 0);
    check_eq("reset.addr", int'(addr_w[0]), 0);
    check_eq("reset.total", int'(tot_w[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("idle_stall.busy", int'(busy_w[0]), 0);
    stall_v[0] = 1'b0;

    scan(0, 0);
    check_scan("luma", 0, 18, 15, 3, 3);

    for (int k = 0; k < 16; k++) mem[0][k] = 8'd0;
    scan(0, 0);
    check_scan("all_zero", 0, 18, 15, 0, 0);

    for (int k = 0; k < 16; k++) mem[0][k] = 8'd1;
    scan(0, 0);
    check_scan("all_one", 0, 18, 15, 16, 0);

    load_a();
    scan(0, 1);
    check_scan("stall", 0, 22, 15, 3, 3);

    scan(0, 2);
    check_scan("start_ignored", 0, 18, 15, 3, 3);

    scan(0, 3);
    check_eq("abort.no_done", n_done[0] - b_done, 0);

    scan(0, 0);
    check_scan("after_abort", 0, 18, 15, 3, 3);

    scan(1, 0);
    check_scan("ac15", 1, 17, 14, 7, 7);

    scan(2, 0);
    check_scan("dc4", 2, 6, 3, 1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
